// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD feeder: digit width, error codes,
// converter FSM states and a power-of-ten helper for the scratch range check.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [3:0] ERR_NONE = 4'h0;
    localparam logic [3:0] ERR_BUSY = 4'h1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    function automatic longint unsigned pow10(input int n);
        longint unsigned acc;
        acc = 64'd1;
        for (int i = 0; i < n; i++) begin
            acc = acc * 64'd10;
        end
        return acc;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more,
// so the following left shift carries into the next digit correctly.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (digit_in >= DIGIT_W'(5)) begin
            digit_out = digit_in + DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bin_to_bcd_feeder.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, feeding
// the seven-segment display driver with a held BCD word, overflow flag and error code.
module bin_to_bcd_feeder
    import bcd_pkg::*;
#(
    parameter int BIN_WIDTH = 16,
    parameter int DIGITS    = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [BIN_WIDTH-1:0]   binary,
    output logic                   busy,
    output logic                   done,
    output logic [4*DIGITS-1:0]    bcd,
    output logic                   overflow,
    output logic [3:0]             error
);

    localparam int SCR_DIGITS = DIGITS + 1;
    localparam int SCR_W      = SCR_DIGITS * DIGIT_W;
    localparam int OUT_W      = DIGITS * DIGIT_W;
    localparam int CNT_W      = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

    localparam longint unsigned SCR_RANGE = pow10(SCR_DIGITS);
    localparam longint unsigned BIN_RANGE = 64'd1 << BIN_WIDTH;

    // The spare top digit must be able to hold any input, or overflow detection lies.
    generate
        if (SCR_RANGE <= BIN_RANGE) begin : g_range_check
            $error("bin_to_bcd_feeder: DIGITS+1 BCD digits cannot hold BIN_WIDTH-bit input");
        end
    endgenerate

    state_t                 state_q, state_d;
    logic [BIN_WIDTH-1:0]   shift_q, shift_d;
    logic [SCR_W-1:0]       scratch_q, scratch_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [OUT_W-1:0]       bcd_q, bcd_d;
    logic                   overflow_q, overflow_d;
    logic [3:0]             error_q, error_d;

    logic [SCR_W-1:0]       scratch_adj;
    logic [SCR_W-1:0]       scratch_shifted;

    generate
        for (genvar gi = 0; gi < SCR_DIGITS; gi++) begin : g_adjust
            bcd_digit_adjust u_adjust (
                .digit_in  (scratch_q[gi*DIGIT_W +: DIGIT_W]),
                .digit_out (scratch_adj[gi*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    assign scratch_shifted = {scratch_adj[SCR_W-2:0], shift_q[BIN_WIDTH-1]};

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        count_d    = count_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        error_d    = error_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = binary;
                    scratch_d = '0;
                    count_d   = CNT_W'(BIN_WIDTH - 1);
                    busy_d    = 1'b1;
                    error_d   = ERR_NONE;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // A request arriving mid-conversion is dropped but remembered as an error.
                if (start) begin
                    error_d = ERR_BUSY;
                end
                scratch_d = scratch_shifted;
                shift_d   = shift_q << 1;
                count_d   = count_q - CNT_W'(1);
                if (count_q == '0) begin
                    bcd_d      = scratch_shifted[OUT_W-1:0];
                    overflow_d = |scratch_shifted[SCR_W-1 -: DIGIT_W];
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            error_q    <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            error_q    <= error_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = overflow_q;
    assign error    = error_q;

endmodule

// File: tb/tb_bin_to_bcd_feeder.sv
// Scoreboard bench for bin_to_bcd_feeder: a cycle model predicts busy/done/error,
// expected BCD results are queued on accepted starts and popped on each done pulse.
module tb_bin_to_bcd_feeder;

    localparam int BIN_WIDTH = 16;
    localparam int DIGITS    = 4;

    typedef struct packed {
        logic [15:0] bcd;
        logic        ov;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] binary;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        overflow;
    logic [3:0]  error;

    exp_t exp_q[$];
    exp_t hold = '0;

    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic [3:0] m_err  = 4'h0;
    int         m_cnt  = 0;

    int n_checks = 0;
    int n_errors = 0;

    bin_to_bcd_feeder #(
        .BIN_WIDTH (BIN_WIDTH),
        .DIGITS    (DIGITS)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .binary   (binary),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow),
        .error    (error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t calc(input int unsigned v);
        exp_t        e;
        int unsigned m;
        e.ov = (v >= 10000);
        m    = v % 10000;
        for (int d = 0; d < 4; d++) begin
            e.bcd[d*4 +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return e;
    endfunction

    // Behavioural cycle model: acceptance, busy window, done pulse, error code.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_err  = 4'h0;
            m_cnt  = 0;
            hold   = '0;
            exp_q.delete();
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1'b1;
                    m_cnt  = BIN_WIDTH;
                    m_err  = 4'h0;
                    exp_q.push_back(calc(int'(binary)));
                end
            end else begin
                if (start) m_err = 4'h1;
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    end

    // Monitor on the falling edge, away from the active edge.
    always @(negedge clock) begin
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
        check("error", 32'(error), 32'(m_err));
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_empty_on_done", 32'd1, 32'd0);
            end else begin
                hold = exp_q.pop_front();
                $display("done: bcd=%04h ovf=%0b err=%0h (expected bcd=%04h ovf=%0b)",
                         bcd, overflow, error, hold.bcd, hold.ov);
            end
        end
        check("bcd", 32'(bcd), 32'(hold.bcd));
        check("overflow", 32'(overflow), 32'(hold.ov));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
    endtask

    task automatic convert(input logic [15:0] v);
        int n;
        binary = v;
        start  = 1'b1;
        tick(1);
        start  = 1'b0;
        wait_done(n);
        check("latency", 32'(n), 32'(BIN_WIDTH));
        tick(1);
    endtask

    initial begin
        int n;
        reset  = 1'b1;
        start  = 1'b0;
        binary = '0;
        tick(3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        reset = 1'b0;
        tick(2);

        // Plain conversions including overflow boundaries.
        convert(16'h04D2);
        convert(16'd0);
        convert(16'd9999);
        convert(16'd10000);
        check("ovf_10000", 32'(overflow), 32'd1);
        convert(16'hFFFF);
        check("bcd_65535", 32'(bcd), 32'h5535);

        // Start dropped while busy.
        binary = 16'd1234;
        start  = 1'b1;
        tick(1);
        start  = 1'b0;
        tick(4);
        binary = 16'd42;
        start  = 1'b1;
        tick(1);
        start  = 1'b0;
        check("err_after_drop", 32'(error), 32'h1);
        wait_done(n);
        check("drop_latency", 32'(n), 32'(BIN_WIDTH - 5));
        check("drop_bcd", 32'(bcd), 32'h1234);
        tick(2);
        check("err_held", 32'(error), 32'h1);
        convert(16'd42);
        check("err_cleared", 32'(error), 32'h0);
        check("bcd_42", 32'(bcd), 32'h0042);

        // Reset mid-conversion.
        binary = 16'd9999;
        start  = 1'b1;
        tick(1);
        start  = 1'b0;
        tick(7);
        reset  = 1'b1;
        tick(1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bcd", 32'(bcd), 32'd0);
        reset = 1'b0;
        tick(20);
        convert(16'd7);
        check("bcd_7", 32'(bcd), 32'h0007);

        // Start held high: back-to-back conversions.
        binary = 16'd123;
        start  = 1'b1;
        tick(40);
        start  = 1'b0;
        tick(25);
        check("held_bcd", 32'(bcd), 32'h0123);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
